// File: rtl/alu_seq.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : alu_seq                                                    |
// | Description : Registered MIPS-style ALU with an iterative radix-2        |
// |               multiply/divide unit and HI/LO registers. Operands and op  |
// |               code are captured when start is accepted. Single-cycle ops |
// |               complete on the following edge. MULT/MULTU/DIV/DIVU take a |
// |               load cycle, WIDTH iteration cycles and one sign-fix cycle. |
// | Options     : ALU_OVERFLOW_EN - adds the 'ovf' port (signed overflow of  |
// |               ADD/SUB, registered with done).                            |
// | Revision    : 1.0  initial release                                       |
// +--------------------------------------------------------------------------+
module alu_seq #(
  parameter int WIDTH = 32,
  parameter int SHW   = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [3:0]       aluCtrl,
  input  logic [WIDTH-1:0] input1,
  input  logic [WIDTH-1:0] input2,
  output logic [WIDTH-1:0] result,
  output logic             zero,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
`ifdef ALU_OVERFLOW_EN
  ,
  output logic             ovf
`endif
);

  // Op code map
  localparam logic [3:0] c_OP_AND   = 4'b0000;
  localparam logic [3:0] c_OP_OR    = 4'b0001;
  localparam logic [3:0] c_OP_ADD   = 4'b0010;
  localparam logic [3:0] c_OP_MFLO  = 4'b0011;
  localparam logic [3:0] c_OP_SLL   = 4'b0100;
  localparam logic [3:0] c_OP_SRL   = 4'b0101;
  localparam logic [3:0] c_OP_SUB   = 4'b0110;
  localparam logic [3:0] c_OP_SLT   = 4'b0111;
  localparam logic [3:0] c_OP_SLTU  = 4'b1000;
  localparam logic [3:0] c_OP_SRA   = 4'b1001;
  localparam logic [3:0] c_OP_MULT  = 4'b1010;
  localparam logic [3:0] c_OP_MULTU = 4'b1011;
  localparam logic [3:0] c_OP_NOR   = 4'b1100;
  localparam logic [3:0] c_OP_DIV   = 4'b1101;
  localparam logic [3:0] c_OP_DIVU  = 4'b1110;
  localparam logic [3:0] c_OP_MFHI  = 4'b1111;

  // Iteration counter value on the final radix-2 step
  localparam logic [SHW-1:0] c_LAST = SHW'(WIDTH - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_ITER = 2'd1,
    S_FIN  = 2'd2
  } state_t;

  state_t           r_state;
  logic             r_go;       // an accepted op is waiting in r_op/r_a/r_b
  logic [3:0]       r_op;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;

  // Iterative unit: {r_acc_hi, r_acc_lo} is the product shifter for multiply
  // and {remainder, dividend/quotient} shifter for divide.
  logic [WIDTH-1:0] r_mcand;    // |multiplicand| or |divisor|
  logic [WIDTH-1:0] r_acc_hi;
  logic [WIDTH-1:0] r_acc_lo;
  logic [SHW-1:0]   r_cnt;
  logic             r_neg_q;    // negate product / quotient at the end
  logic             r_neg_r;    // negate remainder at the end
  logic             r_divz;     // divisor was zero
  logic             r_is_div;

  logic             w_op_mc;
  logic             w_accept;
  logic             w_signed;
  logic [WIDTH-1:0] w_abs_a;
  logic [WIDTH-1:0] w_abs_b;
  logic [WIDTH-1:0] w_sum;
  logic [WIDTH-1:0] w_diff;
  logic [SHW-1:0]   w_shamt;
  logic [WIDTH-1:0] w_alu;
  logic [WIDTH:0]   w_mul_sum;
  logic [WIDTH:0]   w_div_trial;
  logic [2*WIDTH-1:0] w_prod;
  logic [WIDTH-1:0] w_fin_hi;
  logic [WIDTH-1:0] w_fin_lo;

  function automatic logic f_is_mc(input logic [3:0] op);
    return (op == c_OP_MULT) || (op == c_OP_MULTU) ||
           (op == c_OP_DIV)  || (op == c_OP_DIVU);
  endfunction

  // A pending multi-cycle op still counts as occupied until busy rises
  assign w_op_mc  = f_is_mc(r_op);
  assign w_accept = start && (r_state == S_IDLE) && !(r_go && w_op_mc);

  // Operand magnitudes for the signed multiply/divide variants
  assign w_signed = (r_op == c_OP_MULT) || (r_op == c_OP_DIV);
  assign w_abs_a  = (w_signed && r_a[WIDTH-1]) ? (~r_a + 1'b1) : r_a;
  assign w_abs_b  = (w_signed && r_b[WIDTH-1]) ? (~r_b + 1'b1) : r_b;

  // Single-cycle result computed from the captured operands
  always_comb begin
    w_sum   = r_a + r_b;
    w_diff  = r_a - r_b;
    w_shamt = r_a[SHW-1:0];
    w_alu   = '0;
    case (r_op)
      c_OP_AND:  w_alu = r_a & r_b;
      c_OP_OR:   w_alu = r_a | r_b;
      c_OP_ADD:  w_alu = w_sum;
      c_OP_MFLO: w_alu = lo;
      c_OP_SLL:  w_alu = r_b << w_shamt;
      c_OP_SRL:  w_alu = r_b >> w_shamt;
      c_OP_SUB:  w_alu = w_diff;
      c_OP_SLT:  w_alu = {{(WIDTH-1){1'b0}}, ($signed(r_a) < $signed(r_b))};
      c_OP_SLTU: w_alu = {{(WIDTH-1){1'b0}}, (r_a < r_b)};
      c_OP_SRA:  w_alu = $unsigned($signed(r_b) >>> w_shamt);
      c_OP_NOR:  w_alu = ~(r_a | r_b);
      c_OP_MFHI: w_alu = hi;
      default:   w_alu = '0;
    endcase
  end

`ifdef ALU_OVERFLOW_EN
  logic w_ovf;

  // Signed overflow: operands agree in sign (ADD) / differ (SUB) but result flips
  always_comb begin
    w_ovf = 1'b0;
    if (r_op == c_OP_ADD) begin
      w_ovf = (r_a[WIDTH-1] == r_b[WIDTH-1]) && (w_sum[WIDTH-1] != r_a[WIDTH-1]);
    end else if (r_op == c_OP_SUB) begin
      w_ovf = (r_a[WIDTH-1] != r_b[WIDTH-1]) && (w_diff[WIDTH-1] != r_a[WIDTH-1]);
    end
  end
`endif

  // One radix-2 step: shift-add for multiply, restoring trial subtract for divide
  assign w_mul_sum   = {1'b0, r_acc_hi} + (r_acc_lo[0] ? {1'b0, r_mcand} : {(WIDTH+1){1'b0}});
  assign w_div_trial = {r_acc_hi, r_acc_lo[WIDTH-1]} - {1'b0, r_mcand};

  // Sign correction and divide special cases applied in the final cycle
  always_comb begin
    w_prod   = {r_acc_hi, r_acc_lo};
    w_fin_hi = r_acc_hi;
    w_fin_lo = r_acc_lo;
    if (r_is_div) begin
      if (r_divz) begin
        w_fin_lo = '1;
        w_fin_hi = r_a;
      end else begin
        w_fin_lo = r_neg_q ? (~r_acc_lo + 1'b1) : r_acc_lo;
        w_fin_hi = r_neg_r ? (~r_acc_hi + 1'b1) : r_acc_hi;
      end
    end else if (r_neg_q) begin
      w_prod   = ~{r_acc_hi, r_acc_lo} + 1'b1;
      w_fin_hi = w_prod[2*WIDTH-1:WIDTH];
      w_fin_lo = w_prod[WIDTH-1:0];
    end
  end

  // Operation capture, control FSM, iterative datapath and registered outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state  <= S_IDLE;
      r_go     <= 1'b0;
      r_op     <= '0;
      r_a      <= '0;
      r_b      <= '0;
      r_mcand  <= '0;
      r_acc_hi <= '0;
      r_acc_lo <= '0;
      r_cnt    <= '0;
      r_neg_q  <= 1'b0;
      r_neg_r  <= 1'b0;
      r_divz   <= 1'b0;
      r_is_div <= 1'b0;
      result   <= '0;
      zero     <= 1'b1;
      busy     <= 1'b0;
      done     <= 1'b0;
      hi       <= '0;
      lo       <= '0;
`ifdef ALU_OVERFLOW_EN
      ovf      <= 1'b0;
`endif
    end else begin
      done <= 1'b0;
      r_go <= w_accept;
      if (w_accept) begin
        r_op <= aluCtrl;
        r_a  <= input1;
        r_b  <= input2;
      end
      case (r_state)
        S_IDLE: begin
          if (r_go) begin
            if (w_op_mc) begin
              r_mcand  <= w_abs_b;
              r_acc_hi <= '0;
              r_acc_lo <= w_abs_a;
              r_cnt    <= '0;
              r_neg_q  <= w_signed && (r_a[WIDTH-1] ^ r_b[WIDTH-1]);
              r_neg_r  <= w_signed && r_a[WIDTH-1];
              r_divz   <= (r_b == '0);
              r_is_div <= (r_op == c_OP_DIV) || (r_op == c_OP_DIVU);
              busy     <= 1'b1;
              r_state  <= S_ITER;
            end else begin
              result <= w_alu;
              zero   <= (w_alu == '0);
              done   <= 1'b1;
`ifdef ALU_OVERFLOW_EN
              ovf    <= w_ovf;
`endif
            end
          end
        end
        S_ITER: begin
          if (!r_is_div) begin
            {r_acc_hi, r_acc_lo} <= {w_mul_sum, r_acc_lo[WIDTH-1:1]};
          end else if (!w_div_trial[WIDTH]) begin
            r_acc_hi <= w_div_trial[WIDTH-1:0];
            r_acc_lo <= {r_acc_lo[WIDTH-2:0], 1'b1};
          end else begin
            r_acc_hi <= {r_acc_hi[WIDTH-2:0], r_acc_lo[WIDTH-1]};
            r_acc_lo <= {r_acc_lo[WIDTH-2:0], 1'b0};
          end
          r_cnt <= r_cnt + 1'b1;
          if (r_cnt == c_LAST) begin
            r_state <= S_FIN;
          end
        end
        S_FIN: begin
          hi      <= w_fin_hi;
          lo      <= w_fin_lo;
          result  <= w_fin_lo;
          zero    <= (w_fin_lo == '0);
          done    <= 1'b1;
          busy    <= 1'b0;
`ifdef ALU_OVERFLOW_EN
          ovf     <= 1'b0;
`endif
          r_state <= S_IDLE;
        end
        default: begin
          busy    <= 1'b0;
          r_state <= S_IDLE;
        end
      endcase
    end
  end

endmodule
`default_nettype wire
